// File: rtl/gomoku_pkg.sv
// Shared gomoku board definitions: geometry, cell and game-state codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gomoku_pkg;

   localparam int BOARD_W     = 15;
   localparam int BOARD_H     = 15;
   localparam int CELLS       = BOARD_W * BOARD_H;
   localparam int PTR_W       = 8;
   localparam int CHK_TIMEOUT = 1024;

   // Cell contents; 2'b11 is never stored.
   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P0    = 2'b01;
   localparam logic [1:0] CELL_P1    = 2'b10;

   // Game outcome reported on the state port.
   localparam logic [1:0] GS_PLAY  = 2'd0;
   localparam logic [1:0] GS_P0WIN = 2'd1;
   localparam logic [1:0] GS_P1WIN = 2'd2;
   localparam logic [1:0] GS_DRAW  = 2'd3;

   typedef enum logic [2:0] {
      ST_CLEAR  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_LOOKUP = 3'd2,
      ST_START  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_OVER   = 3'd5
   } fsm_e;

   // Stone code for a player: player0 -> 01, player1 -> 10.
   function automatic logic [1:0] player_cell(input logic player);
      return {player, ~player};
   endfunction

endpackage

// File: rtl/board_ram.sv
// Board storage: 2-bit cells, one synchronous write port, registered external read, combinational internal read.
// Latency: write visible next cycle; external read data 1 cycle after address; internal read same cycle.
// Backpressure: none, every port accepts an access every cycle; out-of-range addresses read as empty and never write.
module board_ram #(
   parameter int DEPTH = 225,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [1:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [1:0]    rd_data,
   input  logic [AW-1:0] lk_addr,
   output logic [1:0]    lk_data
);
   import gomoku_pkg::*;

   localparam logic [31:0] DEPTH_U = DEPTH;

   logic [1:0] mem_q [DEPTH];
   logic [1:0] rd_data_q;
   logic [1:0] rd_data_d;

   // Both read ports fold out-of-range addresses to an empty cell.
   always_comb begin
      rd_data_d = CELL_EMPTY;
      lk_data   = CELL_EMPTY;
      if (32'(rd_addr) < DEPTH_U) rd_data_d = mem_q[rd_addr];
      if (32'(lk_addr) < DEPTH_U) lk_data   = mem_q[lk_addr];
   end

   // Cell array: no reset, the owner clears it cell by cell.
   always_ff @(posedge clk) begin
      if (wr_en && (32'(wr_addr) < DEPTH_U)) mem_q[wr_addr] <= wr_data;
   end

   // External read register, so the checker sees the board as of the previous write.
   always_ff @(posedge clk) begin
      if (reset) rd_data_q <= CELL_EMPTY;
      else       rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/board_writer.sv
// Write side of the gomoku board: validates a placement, commits the stone, runs the win check, updates game state.
// Latency: place_req to chk_start 3 cycles; board clear takes CELLS cycles after reset/new_game.
// Backpressure: place_req while busy or after game over is dropped; bad placements get a 1-cycle reject.
module board_writer #(
   parameter int BOARD_W     = gomoku_pkg::BOARD_W,
   parameter int BOARD_H     = gomoku_pkg::BOARD_H,
   parameter int CELLS       = BOARD_W * BOARD_H,
   parameter int PTR_W       = gomoku_pkg::PTR_W,
   parameter int CHK_TIMEOUT = gomoku_pkg::CHK_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             new_game,
   input  logic             place_req,
   input  logic [PTR_W-1:0] pointer,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [1:0]       rd_data,
   output logic             chk_start,
   output logic [PTR_W-1:0] chk_pointer,
   input  logic             chk_done,
   input  logic             chk_success,
   output logic             curr_player,
   output logic [1:0]       state,
   output logic             busy,
   output logic             reject
);
   import gomoku_pkg::*;

   localparam int               SC_W     = $clog2(CELLS + 1);
   localparam int               TO_W     = (CHK_TIMEOUT > 1) ? $clog2(CHK_TIMEOUT) : 1;
   localparam logic [31:0]      CELLS_U  = CELLS;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(CELLS - 1);
   localparam logic [SC_W-1:0]  FULL_CNT = SC_W'(CELLS);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CHK_TIMEOUT - 1);

   fsm_e             fsm_q, fsm_d;
   logic [PTR_W-1:0] clr_idx_q, clr_idx_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] chk_pointer_q, chk_pointer_d;
   logic [SC_W-1:0]  stone_count_q, stone_count_d;
   logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic             curr_player_q, curr_player_d;
   logic             chk_start_q, chk_start_d;
   logic             reject_q, reject_d;
   logic [1:0]       state_q, state_d;

   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic [1:0]       wr_data;
   logic [1:0]       cell_rd;
   logic             ptr_in_range;

   assign ptr_in_range = (32'(pointer) < CELLS_U);

   board_ram #(
      .DEPTH (CELLS),
      .AW    (PTR_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .lk_addr (ptr_q),
      .lk_data (cell_rd)
   );

   // Next-state, board write port and registered-output values for the placement FSM.
   always_comb begin
      fsm_d         = fsm_q;
      clr_idx_d     = clr_idx_q;
      ptr_d         = ptr_q;
      chk_pointer_d = chk_pointer_q;
      stone_count_d = stone_count_q;
      wait_cnt_d    = wait_cnt_q;
      curr_player_d = curr_player_q;
      state_d       = state_q;
      chk_start_d   = 1'b0;
      reject_d      = 1'b0;
      wr_en         = 1'b0;
      wr_addr       = clr_idx_q;
      wr_data       = CELL_EMPTY;

      if (new_game) begin
         // Behaves like reset and wins over any simultaneous request or verdict.
         fsm_d         = ST_CLEAR;
         clr_idx_d     = '0;
         ptr_d         = '0;
         chk_pointer_d = '0;
         stone_count_d = '0;
         wait_cnt_d    = '0;
         curr_player_d = 1'b0;
         state_d       = GS_PLAY;
      end else begin
         case (fsm_q)
            ST_CLEAR: begin
               wr_en   = 1'b1;
               wr_addr = clr_idx_q;
               if (clr_idx_q == LAST_IDX) fsm_d = ST_IDLE;
               else                       clr_idx_d = clr_idx_q + 1'b1;
            end
            ST_IDLE: begin
               if (place_req && (state_q == GS_PLAY)) begin
                  if (!ptr_in_range) begin
                     reject_d = 1'b1;
                  end else begin
                     ptr_d = pointer;
                     fsm_d = ST_LOOKUP;
                  end
               end
            end
            ST_LOOKUP: begin
               if (cell_rd != CELL_EMPTY) begin
                  reject_d = 1'b1;
                  fsm_d    = ST_IDLE;
               end else begin
                  wr_en         = 1'b1;
                  wr_addr       = ptr_q;
                  wr_data       = player_cell(curr_player_q);
                  stone_count_d = stone_count_q + 1'b1;
                  fsm_d         = ST_START;
               end
            end
            ST_START: begin
               chk_start_d   = 1'b1;
               chk_pointer_d = ptr_q;
               wait_cnt_d    = '0;
               fsm_d         = ST_WAIT;
            end
            ST_WAIT: begin
               // A silent checker is treated as "no five-in-a-row" once the budget runs out.
               if (chk_done || (wait_cnt_q == TO_LAST)) begin
                  if (chk_done && chk_success) begin
                     state_d = curr_player_q ? GS_P1WIN : GS_P0WIN;
                     fsm_d   = ST_OVER;
                  end else if (stone_count_q == FULL_CNT) begin
                     state_d = GS_DRAW;
                     fsm_d   = ST_OVER;
                  end else begin
                     curr_player_d = ~curr_player_q;
                     fsm_d         = ST_IDLE;
                  end
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
            ST_OVER: begin
               fsm_d = ST_OVER;
            end
            default: begin
               fsm_d     = ST_CLEAR;
               clr_idx_d = '0;
            end
         endcase
      end
   end

   // State and registered outputs; reset starts a fresh board clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q         <= ST_CLEAR;
         clr_idx_q     <= '0;
         ptr_q         <= '0;
         chk_pointer_q <= '0;
         stone_count_q <= '0;
         wait_cnt_q    <= '0;
         curr_player_q <= 1'b0;
         state_q       <= GS_PLAY;
         chk_start_q   <= 1'b0;
         reject_q      <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         clr_idx_q     <= clr_idx_d;
         ptr_q         <= ptr_d;
         chk_pointer_q <= chk_pointer_d;
         stone_count_q <= stone_count_d;
         wait_cnt_q    <= wait_cnt_d;
         curr_player_q <= curr_player_d;
         state_q       <= state_d;
         chk_start_q   <= chk_start_d;
         reject_q      <= reject_d;
      end
   end

   assign chk_start   = chk_start_q;
   assign chk_pointer = chk_pointer_q;
   assign curr_player = curr_player_q;
   assign state       = state_q;
   assign reject      = reject_q;
   assign busy        = (fsm_q != ST_IDLE);

endmodule
